// File: rtl/mastermind_scorer.sv
// Mastermind feedback engine: scores a captured guess against a secret (exact hits,
// then colour-only hits with correct multiplicity), tracks game progress and drives the LED bar.
module mastermind_scorer #(
  parameter int NUM_POS     = 4,
  parameter int SYM_W       = 3,
  parameter int MAX_GUESSES = 10,
  parameter int BLINK_SPEED = 25000000,
  parameter int LED_MODE    = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             new_game,
  input  logic [NUM_POS*SYM_W-1:0]         guess_val,
  input  logic [NUM_POS*SYM_W-1:0]         secret_val,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NUM_POS+1)-1:0]     exact_cnt,
  output logic [$clog2(NUM_POS+1)-1:0]     partial_cnt,
  output logic                             win,
  output logic                             game_over,
  output logic [$clog2(MAX_GUESSES+1)-1:0] guess_count,
  output logic [2*NUM_POS-1:0]             leds
);

  localparam int CODE_W = NUM_POS * SYM_W;
  localparam int CNT_W  = $clog2(NUM_POS + 1);
  localparam int GC_W   = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W  = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int TMR_W  = (BLINK_SPEED > 0) ? $clog2(BLINK_SPEED + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXACT,
    S_PARTIAL,
    S_REPORT
  } state_t;

  state_t state, state_nxt;

  logic [CODE_W-1:0]    guess_q, secret_q;
  logic [NUM_POS-1:0]   exact_mask;
  logic [CNT_W-1:0]     exact_acc, partial_acc;
  logic [IDX_W-1:0]     idx;
  logic [SYM_W-1:0]     sym;
  logic [2*NUM_POS-1:0] led_pat;
  logic                 blink_state;
  logic [TMR_W-1:0]     blink_tmr;

  logic [SYM_W-1:0] g_sym [NUM_POS];
  logic [SYM_W-1:0] s_sym [NUM_POS];

  logic                 accept;
  logic                 exact_hit;
  logic [CNT_W-1:0]     g_hits, s_hits, sym_min;
  logic [2*NUM_POS-1:0] led_cnt, led_pos, led_nxt;
  logic                 any_hit;
  logic                 win_nxt;
  logic [GC_W-1:0]      gc_nxt;
  logic                 over_nxt;

  for (genvar p = 0; p < NUM_POS; p++) begin : g_unpack
    assign g_sym[p] = guess_q[p*SYM_W +: SYM_W];
    assign s_sym[p] = secret_q[p*SYM_W +: SYM_W];
  end

  assign accept    = (state == S_IDLE) && start && !game_over && !new_game;
  assign exact_hit = (g_sym[idx] == s_sym[idx]);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept) state_nxt = S_EXACT;
      S_EXACT:   if (idx == IDX_W'(NUM_POS - 1)) state_nxt = S_PARTIAL;
      S_PARTIAL: if (sym == '1) state_nxt = S_REPORT;
      S_REPORT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (new_game) state_nxt = S_IDLE;
  end

  // Colour-only contribution of symbol value `sym` over the positions not already exact.
  always_comb begin
    g_hits = '0;
    s_hits = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (!exact_mask[i] && (g_sym[i] == sym)) g_hits = g_hits + CNT_W'(1);
      if (!exact_mask[i] && (s_sym[i] == sym)) s_hits = s_hits + CNT_W'(1);
    end
    sym_min = (g_hits < s_hits) ? g_hits : s_hits;
  end

  always_comb begin
    led_cnt = '0;
    for (int k = 0; k < NUM_POS; k++) begin
      if (k < int'(exact_acc))
        led_cnt[2*(NUM_POS-1-k) +: 2] = 2'b11;
      else if (k < int'(exact_acc) + int'(partial_acc))
        led_cnt[2*(NUM_POS-1-k) +: 2] = 2'b01;
    end
  end

  // Positional mode lights 01 when the guess symbol appears anywhere in the unmatched secret.
  always_comb begin
    led_pos = '0;
    any_hit = 1'b0;
    for (int i = 0; i < NUM_POS; i++) begin
      any_hit = 1'b0;
      for (int j = 0; j < NUM_POS; j++)
        if (!exact_mask[j] && (g_sym[i] == s_sym[j])) any_hit = 1'b1;
      if (exact_mask[i])
        led_pos[2*i +: 2] = 2'b11;
      else if (any_hit)
        led_pos[2*i +: 2] = 2'b01;
    end
  end

  assign led_nxt  = (LED_MODE == 0) ? led_pos : led_cnt;
  assign win_nxt  = (exact_acc == CNT_W'(NUM_POS));
  assign gc_nxt   = (guess_count == GC_W'(MAX_GUESSES)) ? guess_count : guess_count + GC_W'(1);
  assign over_nxt = win_nxt || (gc_nxt == GC_W'(MAX_GUESSES));

  assign leds = game_over ? {(2*NUM_POS){blink_state}} : led_pat;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: operand and mask registers are reset as well, so nothing depends on power-up contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guess_q     <= '0;
      secret_q    <= '0;
      exact_mask  <= '0;
      exact_acc   <= '0;
      partial_acc <= '0;
      idx         <= '0;
      sym         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      exact_cnt   <= '0;
      partial_cnt <= '0;
      win         <= 1'b0;
      game_over   <= 1'b0;
      guess_count <= '0;
      led_pat     <= '0;
      blink_state <= 1'b0;
      blink_tmr   <= '0;
    end else if (new_game) begin
      exact_mask  <= '0;
      exact_acc   <= '0;
      partial_acc <= '0;
      idx         <= '0;
      sym         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      exact_cnt   <= '0;
      partial_cnt <= '0;
      win         <= 1'b0;
      game_over   <= 1'b0;
      guess_count <= '0;
      led_pat     <= '0;
      blink_state <= 1'b0;
      blink_tmr   <= '0;
    end else begin
      done <= 1'b0;

      if (game_over) begin
        if (blink_tmr == TMR_W'(BLINK_SPEED)) begin
          blink_tmr   <= '0;
          blink_state <= ~blink_state;
        end else begin
          blink_tmr <= blink_tmr + TMR_W'(1);
        end
      end

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            guess_q     <= guess_val;
            secret_q    <= secret_val;
            exact_mask  <= '0;
            exact_acc   <= '0;
            partial_acc <= '0;
            idx         <= '0;
            sym         <= '0;
            busy        <= 1'b1;
          end
        end
        S_EXACT: begin
          if (exact_hit) begin
            exact_mask[idx] <= 1'b1;
            exact_acc       <= exact_acc + CNT_W'(1);
          end
          idx <= idx + IDX_W'(1);
        end
        S_PARTIAL: begin
          partial_acc <= partial_acc + sym_min;
          sym         <= sym + SYM_W'(1);
        end
        S_REPORT: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          exact_cnt   <= exact_acc;
          partial_cnt <= partial_acc;
          led_pat     <= led_nxt;
          win         <= win_nxt;
          guess_count <= gc_nxt;
          if (over_nxt) begin
            game_over   <= 1'b1;
            blink_state <= 1'b1;
            blink_tmr   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Self-checking bench for mastermind_scorer: scoreboard of expected results, one task per scenario,
// with a count-mode and a positional-mode instance driven in parallel.
module tb_mastermind_scorer;

  localparam logic [11:0] SECRET = 12'h29C;
  localparam int          LAT    = 13;

  typedef struct packed {
    logic [2:0] exact;
    logic [2:0] partial;
    logic [7:0] leds;
    logic [7:0] leds_pos;
    logic       win;
    logic       game_over;
    logic [3:0] gcount;
    logic       busy;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        new_game = 1'b0;
  logic [11:0] guess_val = '0;
  logic [11:0] secret_val = SECRET;

  logic       busy, done, win, game_over;
  logic [2:0] exact_cnt, partial_cnt;
  logic [3:0] guess_count;
  logic [7:0] leds;

  logic       p_busy, p_done, p_win, p_game_over;
  logic [2:0] p_exact_cnt, p_partial_cnt;
  logic [3:0] p_guess_count;
  logic [7:0] p_leds;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  mastermind_scorer #(.BLINK_SPEED(3), .LED_MODE(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .new_game(new_game),
    .guess_val(guess_val), .secret_val(secret_val),
    .busy(busy), .done(done), .exact_cnt(exact_cnt), .partial_cnt(partial_cnt),
    .win(win), .game_over(game_over), .guess_count(guess_count), .leds(leds)
  );

  mastermind_scorer #(.BLINK_SPEED(3), .LED_MODE(0)) dut_pos (
    .clk(clk), .reset_n(reset_n), .start(start), .new_game(new_game),
    .guess_val(guess_val), .secret_val(secret_val),
    .busy(p_busy), .done(p_done), .exact_cnt(p_exact_cnt), .partial_cnt(p_partial_cnt),
    .win(p_win), .game_over(p_game_over), .guess_count(p_guess_count), .leds(p_leds)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic res_t observe();
    res_t r;
    r.exact     = exact_cnt;
    r.partial   = partial_cnt;
    r.leds      = leds;
    r.leds_pos  = p_leds;
    r.win       = win;
    r.game_over = game_over;
    r.gcount    = guess_count;
    r.busy      = busy;
    return r;
  endfunction

  // Reference scorer: histogram of unmatched symbols on each side, min per colour.
  function automatic res_t model(input logic [11:0] g, input logic [3:0] gc, input logic go);
    res_t       r;
    logic [11:0] s;
    int         gh[8];
    int         sh[8];
    int         e, p;
    logic [3:0] m;
    logic       hit;
    s = SECRET;
    r = '0;
    e = 0;
    p = 0;
    m = '0;
    for (int v = 0; v < 8; v++) begin gh[v] = 0; sh[v] = 0; end
    for (int i = 0; i < 4; i++) begin
      if (g[3*i +: 3] == s[3*i +: 3]) begin
        m[i] = 1'b1;
        e++;
      end else begin
        gh[g[3*i +: 3]]++;
        sh[s[3*i +: 3]]++;
      end
    end
    for (int v = 0; v < 8; v++) p += (gh[v] < sh[v]) ? gh[v] : sh[v];
    r.exact   = 3'(e);
    r.partial = 3'(p);
    for (int k = 0; k < 4; k++) begin
      if (k < e)          r.leds[2*(3-k) +: 2] = 2'b11;
      else if (k < e + p) r.leds[2*(3-k) +: 2] = 2'b01;
    end
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++) if (!m[j] && g[3*i +: 3] == s[3*j +: 3]) hit = 1'b1;
      if (m[i])     r.leds_pos[2*i +: 2] = 2'b11;
      else if (hit) r.leds_pos[2*i +: 2] = 2'b01;
    end
    if (go) begin
      r.leds     = 8'hFF;
      r.leds_pos = 8'hFF;
    end
    r.win       = (e == 4);
    r.game_over = go;
    r.gcount    = gc;
    r.busy      = 1'b0;
    return r;
  endfunction

  // Pulses start for one edge, then waits (bounded) for done and captures the results.
  task automatic run_eval(input logic [11:0] g, input bit toggle,
                          output res_t obs, output int lat, output int pulses, output logic b0);
    @(negedge clk);
    guess_val = g;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    b0     = busy;
    lat    = -1;
    pulses = 0;
    obs    = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          obs = observe();
        end
      end
      if (toggle) begin
        guess_val = 12'($urandom);
        start     = (n < 10) ? n[0] : 1'b0;
      end
      if (!toggle && lat >= 0) break;
    end
  endtask

  task automatic test_reset();
    res_t obs;
    reset_n = 1'b0;
    #12;
    obs = observe();
    n_cmp++;
    if (obs !== '0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %h done=%b, want all zero", obs, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mixed_colours();
    res_t obs, e;
    int   lat, pulses;
    logic b0;
    exp_q.push_back('{exact: 3'd0, partial: 3'd4, leds: 8'h55, leds_pos: 8'h55,
                      win: 1'b0, game_over: 1'b0, gcount: 4'd1, busy: 1'b0});
    run_eval(12'h8D1, 1'b0, obs, lat, pulses, b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL mixed_result: got %h want %h", obs, e); end
    n_cmp++;
    if (lat !== LAT) begin n_bad++; $display("FAIL mixed_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (b0 !== 1'b1) begin n_bad++; $display("FAIL mixed_busy_start: got %b want 1", b0); end
  endtask

  task automatic test_single_exact();
    res_t obs, e;
    int   lat, pulses;
    logic b0;
    exp_q.push_back('{exact: 3'd1, partial: 3'd0, leds: 8'hC0, leds_pos: 8'hC0,
                      win: 1'b0, game_over: 1'b0, gcount: 4'd2, busy: 1'b0});
    run_eval(12'h249, 1'b0, obs, lat, pulses, b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL single_exact: got %h want %h", obs, e); end
  endtask

  task automatic test_repeat_colours();
    res_t obs, e;
    int   lat, pulses;
    logic b0;
    exp_q.push_back('{exact: 3'd1, partial: 3'd1, leds: 8'hD0, leds_pos: 8'h35,
                      win: 1'b0, game_over: 1'b0, gcount: 4'd3, busy: 1'b0});
    run_eval(12'h489, 1'b1, obs, lat, pulses, b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL repeat_result: got %h want %h", obs, e); end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL repeat_done_pulses: got %0d want 1", pulses); end
    n_cmp++;
    if (lat !== LAT) begin n_bad++; $display("FAIL repeat_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (observe() !== e) begin n_bad++; $display("FAIL repeat_hold: got %h want %h", observe(), e); end
  endtask

  task automatic test_win_blink();
    res_t       obs, e;
    int         lat, pulses, extra;
    logic       b0;
    logic [7:0] want;
    exp_q.push_back('{exact: 3'd4, partial: 3'd0, leds: 8'hFF, leds_pos: 8'hFF,
                      win: 1'b1, game_over: 1'b1, gcount: 4'd4, busy: 1'b0});
    run_eval(SECRET, 1'b0, obs, lat, pulses, b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL win_result: got %h want %h", obs, e); end
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      want = (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
      n_cmp++;
      if (leds !== want) begin
        n_bad++;
        $display("FAIL win_blink[%0d]: got %h want %h", k, leds, want);
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0 || guess_count !== 4'd4) begin
      n_bad++;
      $display("FAIL win_start_ignored: activity=%0d count=%0d want 0/4", extra, guess_count);
    end
  endtask

  task automatic test_game_over();
    res_t        obs, e;
    int          lat, pulses, extra;
    logic        b0;
    logic [11:0] g;
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    n_cmp++;
    if (observe() !== '0) begin n_bad++; $display("FAIL newgame_clear: got %h want 0", observe()); end
    for (int i = 1; i <= 10; i++) begin
      g = 12'($urandom);
      if (g == SECRET) g = g ^ 12'h001;
      exp_q.push_back(model(g, 4'(i), i == 10));
      run_eval(g, 1'b0, obs, lat, pulses, b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL gameover_guess[%0d] %h: got %h want %h", i, g, obs, e); end
    end
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      new_game = 1'b1;
      start    = 1'b1;
      guess_val = 12'h8D1;
      @(negedge clk);
      new_game = 1'b0;
      start    = 1'b0;
      n_cmp++;
      if (observe() !== '0) begin
        n_bad++;
        $display("FAIL newgame_start[%0d]: got %h want 0", r, observe());
      end
      extra = 0;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk);
        #1;
        if (done || busy) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin n_bad++; $display("FAIL newgame_no_eval[%0d]: activity=%0d want 0", r, extra); end
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, e;
    int   lat, pulses;
    logic b0;
    exp_q.push_back(model(12'h8D1, 4'd1, 1'b0));
    run_eval(12'h8D1, 1'b0, obs, lat, pulses, b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_pre_eval: got %h want %h", obs, e); end
    @(negedge clk);
    guess_val = 12'h249;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (observe() !== '0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: got %h done=%b want all zero", observe(), done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(model(12'h489, 4'd1, 1'b0));
    run_eval(12'h489, 1'b0, obs, lat, pulses, b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_fresh_eval: got %h want %h", obs, e); end
    n_cmp++;
    if (lat !== LAT) begin n_bad++; $display("FAIL reset_fresh_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_mixed_colours();
    test_single_exact();
    test_repeat_colours();
    test_win_blink();
    test_game_over();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
Parametrised Mastermind feedback engine. Scores a captured guess against a secret with correct multiplicity: exact hits first, then colour-only hits over the unmatched positions. It tracks guess count, win and game over, and drives the LED feedback bar, including a blinking end-of-game mode. It sits between the guess-entry logic and the board LEDs.

Parameters:
NUM_POS, 4, number of code positions.
SYM_W, 3, bits per symbol; the alphabet size is 2^SYM_W.
MAX_GUESSES, 10, number of guesses before game over without a win.
BLINK_SPEED, 25000000, blink timer terminal count; the LED state toggles every BLINK_SPEED+1 cycles.
LED_MODE, 1, LED encoding: 0 = positional, 1 = count.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request to evaluate guess_val
new_game  in  1  clear game state
guess_val  in  NUM_POS*SYM_W  guess; position NUM_POS-1 in the MS field
secret_val  in  NUM_POS*SYM_W  secret code, same packing
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse when results update
exact_cnt  out  clog2(NUM_POS+1)  exact matches
partial_cnt  out  clog2(NUM_POS+1)  colour-only matches
win  out  1  last evaluation had exact_cnt == NUM_POS
game_over  out  1  sticky end-of-game flag
guess_count  out  clog2(MAX_GUESSES+1)  completed evaluations
leds  out  2*NUM_POS  feedback bar

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0:
  - all outputs are 0;
  - FSM is in IDLE;
  - blink timer is 0 and blink_state is 0.
- FSM states: IDLE, EXACT, PARTIAL, REPORT.
- IDLE:
  - start=1, game_over=0 and new_game=0 → capture guess_val and secret_val.
  - Clear exact_mask, the accumulators and the index; set busy=1; go to EXACT.
  - start is ignored while busy or game_over.
- EXACT:
  - One position per cycle, idx 0..NUM_POS-1.
  - Equal symbols → set exact_mask[idx] and increment the exact accumulator.
  - After idx NUM_POS-1 → PARTIAL.
- PARTIAL:
  - One symbol value v per cycle, v 0..2^SYM_W-1.
  - Add min(count of non-exact guess positions equal to v, count of non-exact secret positions equal to v) to the partial accumulator.
  - After the last v → REPORT.
- REPORT (one cycle):
  - done=1 and busy=0 during this cycle.
  - exact_cnt, partial_cnt, leds and win register from the accumulators.
  - guess_count increments, saturating at MAX_GUESSES.
  - game_over sets if win or the new guess_count == MAX_GUESSES.
  - Next state is IDLE.
- Latency: done is high in the cycle after edge NUM_POS+2^SYM_W+1, counted from the start-capture edge (edge 0). For the defaults this is 13 edges. busy is high from edge 0 through edge NUM_POS+2^SYM_W.
- Captured operands are immune to input changes while busy.
- Result outputs hold their values until the next REPORT, new_game or reset.
- LED_MODE=1 (count mode):
  - From the MS pair downward, the first exact_cnt pairs are 2'b11.
  - The next partial_cnt pairs are 2'b01; the remaining pairs are 2'b00.
- LED_MODE=0 (positional mode):
  - pair i = 2'b11 if exact_mask[i].
  - Otherwise pair i = 2'b01 if guess symbol i equals some secret symbol j with exact_mask[j]=0.
  - Otherwise pair i = 2'b00.
- Blink:
  - On the cycle game_over rises, blink_state=1 and the timer is 0.
  - While game_over: timer counts 0..BLINK_SPEED, then wraps to 0 and toggles blink_state.
  - leds = all ones when blink_state=1, all zeros when blink_state=0.
  - The stored feedback pattern is kept but not driven while game_over.
- new_game (any state):
  - Next edge: state IDLE; busy, done, win and game_over go to 0.
  - guess_count, exact_cnt, partial_cnt and leds go to 0; timer and blink_state go to 0.
  - new_game dominates a simultaneous start.
  - new_game while busy aborts the evaluation: no done, no count change.
- Reset mid-evaluation behaves the same as new_game, except it is asynchronous.
- Arithmetic: the accumulators never exceed NUM_POS, and exact+partial ≤ NUM_POS by construction.

Test Plan:
Defaults, except BLINK_SPEED=3. Secret 12'h29C = symbols 1,2,3,4.
1. Guess 12'h8D1 (4,3,2,1) → done on the 13th edge after the start edge; exact_cnt=0, partial_cnt=4, leds=8'h55, guess_count=1, busy=0.
2. Guess 12'h249 (1,1,1,1) → exact=1, partial=0, leds=8'hC0. In LED_MODE=0 → leds=8'hC0, with no spurious 01 pairs.
3. Guess 12'h489 (2,2,1,1) → exact=1, partial=1, leds=8'hD0. Toggling guess_val and start while busy → result unchanged, with only one done pulse.
4. Guess 12'h29C → exact=4, win=1, game_over=1. leds=8'hFF for 4 cycles, 8'h00 for 4 cycles, repeating. A further start is ignored and guess_count stays unchanged.
5. Ten non-winning guesses → game_over=1 after the 10th done with win=0. new_game and start asserted together → all results clear, no evaluation starts.
6. Assert reset_n=0 at cycle 5 of an evaluation → outputs are 0 immediately. Release and start a fresh evaluation → normal 13-edge latency.
